// File: rtl/ram_bus_arbiter_pkg.sv
// Shared types and helpers for the data-RAM bus arbiter.
// Holds the FSM state type, default RAM window and the address range check.
package ram_bus_pkg;

  typedef enum logic {ARB, OWN} arb_state_t;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h1000;
  localparam int unsigned DEFAULT_RAM_WORDS = 1024;

  // Full 32-bit compare; 33-bit limit so a window ending at 4 GiB cannot wrap.
  function automatic logic in_range(input logic [31:0] addr, input logic [31:0] base,
                                    input int unsigned words);
    logic [32:0] lim;
    lim = {1'b0, base} + (33'(words) << 2);
    return (addr >= base) && ({1'b0, addr} < lim);
  endfunction

endpackage

// File: rtl/ram_bus_arbiter_if.sv
// Multi-master request/grant/read-return bundle for the RAM bus arbiter.
// master: the requester side; slave: the arbiter side.
interface ram_bus_arbiter_if #(
  parameter int unsigned NUM_MASTERS = 2
);
  logic [NUM_MASTERS-1:0]       req;
  logic [NUM_MASTERS-1:0]       lock;
  logic [NUM_MASTERS-1:0]       we;
  logic [NUM_MASTERS-1:0][31:0] addr;
  logic [NUM_MASTERS-1:0][31:0] wdata;
  logic [NUM_MASTERS-1:0]       gnt;
  logic [NUM_MASTERS-1:0]       rvalid;
  logic [31:0]                  rdata;
  logic                         err;

  modport master (
    output req, lock, we, addr, wdata,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, lock, we, addr, wdata,
    output gnt, rvalid, rdata, err
  );
endinterface

// File: rtl/ram_bus_arbiter_rr_picker.sv
// Combinational round-robin picker: one-hot grant to the first requester at or
// after ptr_i, wrapping around.
module rr_picker #(
  parameter int unsigned N  = 2,
  localparam int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o
);

  always_comb begin
    int unsigned c;
    logic        found;
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    c     = 0;
    for (int unsigned off = 0; off < N; off++) begin
      c = (int'(ptr_i) + off) % N;
      if (!found && req_i[c]) begin
        found    = 1'b1;
        gnt_o[c] = 1'b1;
        idx_o    = IW'(c);
      end
    end
  end

endmodule

// File: rtl/ram_bus_arbiter.sv
// Shares the single-port data RAM between NUM_MASTERS requesters with
// round-robin arbitration, locked bursts, range checking and registered read return.
module ram_bus_arbiter import ram_bus_pkg::*; #(
  parameter int unsigned NUM_MASTERS = 2,
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int unsigned RAM_WORDS   = DEFAULT_RAM_WORDS,
  parameter int unsigned MAX_BURST   = 8,
  localparam int unsigned AW = $clog2(RAM_WORDS),
  localparam int unsigned IW = $clog2(NUM_MASTERS),
  localparam int unsigned CW = $clog2(MAX_BURST + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  ram_bus_arbiter_if.slave  bus,
  output logic [AW-1:0]     ram_a_o,
  output logic [31:0]       ram_d_o,
  output logic              ram_we_o,
  input  logic [31:0]       ram_spo_i
);

  arb_state_t             state_q, state_d;
  logic [IW-1:0]          rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]          owner_q, owner_d;
  logic [CW-1:0]          beat_cnt_q, beat_cnt_d;
  logic [NUM_MASTERS-1:0] rvalid_q, rvalid_d;
  logic [31:0]            rdata_q, rdata_d;
  logic                   err_q, err_d;

  logic [NUM_MASTERS-1:0] pick_gnt, gnt;
  logic [IW-1:0]          pick_idx, sel_idx;
  logic [31:0]            sel_addr;
  logic                   sel_we, sel_in_range, granted;

  function automatic logic [IW-1:0] inc_ptr(input logic [IW-1:0] p);
    return (p == IW'(NUM_MASTERS - 1)) ? '0 : p + 1'b1;
  endfunction

  rr_picker #(
    .N (NUM_MASTERS)
  ) u_picker (
    .req_i (bus.req),
    .ptr_i (rr_ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx)
  );

  // Grants are masked while reset is held so gnt_o reads 0 during reset.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    beat_cnt_d = beat_cnt_q;
    gnt        = '0;
    sel_idx    = pick_idx;
    unique case (state_q)
      ARB: begin
        if (rst_ni && (|bus.req)) begin
          gnt = pick_gnt;
          if (bus.lock[pick_idx] && (MAX_BURST > 1)) begin
            state_d    = OWN;
            owner_d    = pick_idx;
            beat_cnt_d = CW'(1);
          end else begin
            rr_ptr_d = inc_ptr(pick_idx);
          end
        end
      end
      OWN: begin
        sel_idx = owner_q;
        // The exit cycle issues no grant, even to the owner.
        if (bus.req[owner_q] && bus.lock[owner_q] && (beat_cnt_q != CW'(MAX_BURST))) begin
          gnt[owner_q] = rst_ni;
          beat_cnt_d   = beat_cnt_q + 1'b1;
        end else begin
          state_d  = ARB;
          rr_ptr_d = inc_ptr(owner_q);
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_comb begin
    sel_addr     = bus.addr[sel_idx];
    sel_we       = bus.we[sel_idx];
    sel_in_range = in_range(sel_addr, BASE_ADDR, RAM_WORDS);
    granted      = |gnt;
    ram_a_o      = AW'((sel_addr - BASE_ADDR) >> 2);
    ram_d_o      = bus.wdata[sel_idx];
    ram_we_o     = granted & sel_we & sel_in_range;

    rvalid_d = '0;
    err_d    = 1'b0;
    rdata_d  = rdata_q;
    if (granted) begin
      if (!sel_we) begin
        rvalid_d = gnt;
        err_d    = !sel_in_range;
        rdata_d  = sel_in_range ? ram_spo_i : 32'h0;
      end else if (!sel_in_range) begin
        rvalid_d = gnt;
        err_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ARB;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      beat_cnt_q <= '0;
      rvalid_q   <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      beat_cnt_q <= beat_cnt_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
    end
  end

  assign bus.gnt    = gnt;
  assign bus.rvalid = rvalid_q;
  assign bus.rdata  = rdata_q;
  assign bus.err    = err_q;

endmodule

// File: tb/tb_ram_bus_arbiter.sv
// Directed bench for ram_bus_arbiter with two masters and a behavioural RAM.
module tb_ram_bus_arbiter;
  import ram_bus_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [9:0]  ram_a;
  logic [31:0] ram_d;
  logic        ram_we;
  logic [31:0] ram_spo;
  logic [31:0] mem [1024];

  int n_checks;
  int n_fail;

  ram_bus_arbiter_if #(.NUM_MASTERS(2)) bus ();

  ram_bus_arbiter #(
    .NUM_MASTERS (2),
    .BASE_ADDR   (32'h1000),
    .RAM_WORDS   (1024),
    .MAX_BURST   (8)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .bus       (bus),
    .ram_a_o   (ram_a),
    .ram_d_o   (ram_d),
    .ram_we_o  (ram_we),
    .ram_spo_i (ram_spo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign ram_spo = mem[ram_a];
  always @(posedge clk) if (ram_we) mem[ram_a] <= ram_d;

  task automatic idle();
    bus.req   = 2'b00;
    bus.lock  = 2'b00;
    bus.we    = 2'b00;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    bus.req = 2'b11;
    repeat (2) @(negedge clk);
    #1;
    n_checks++; if (bus.gnt !== 2'b00) begin
      $display("FAIL reset_gnt: got %b want 00", bus.gnt); n_fail++; end
    n_checks++; if (bus.rvalid !== 2'b00) begin
      $display("FAIL reset_rvalid: got %b want 00", bus.rvalid); n_fail++; end
    n_checks++; if (ram_we !== 1'b0 || bus.err !== 1'b0 || bus.rdata !== 32'h0) begin
      $display("FAIL reset_outs: we=%b err=%b rdata=%h want 0", ram_we, bus.err, bus.rdata);
      n_fail++; end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++; if (bus.gnt !== 2'b01) begin
      $display("FAIL reset_first_gnt: got %b want 01", bus.gnt); n_fail++; end
    idle();
  endtask

  task automatic test_contention();
    logic [1:0] exp_g [4];
    exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.req = 2'b11;
      #1;
      n_checks++; if (bus.gnt !== exp_g[i]) begin
        $display("FAIL contention_%0d: got %b want %b", i, bus.gnt, exp_g[i]); n_fail++; end
    end
    @(negedge clk);
    idle();
  endtask

  task automatic test_write_read();
    bus.req = 2'b01; bus.we = 2'b01;
    bus.addr[0] = 32'h1004; bus.wdata[0] = 32'hDEADBEEF;
    #1;
    n_checks++; if (bus.gnt !== 2'b01 || ram_a !== 10'd1 || ram_we !== 1'b1
                    || ram_d !== 32'hDEADBEEF) begin
      $display("FAIL wr_ram: gnt=%b a=%0d we=%b d=%h want 01 1 1 deadbeef",
               bus.gnt, ram_a, ram_we, ram_d); n_fail++; end
    @(posedge clk); #1;
    n_checks++; if (bus.rvalid !== 2'b00) begin
      $display("FAIL wr_no_rvalid: got %b want 00", bus.rvalid); n_fail++; end
    @(negedge clk);
    bus.we = 2'b00;
    #1;
    n_checks++; if (bus.gnt !== 2'b01 || ram_we !== 1'b0) begin
      $display("FAIL rd_gnt: gnt=%b we=%b want 01 0", bus.gnt, ram_we); n_fail++; end
    @(posedge clk); #1;
    n_checks++; if (bus.rvalid !== 2'b01 || bus.rdata !== 32'hDEADBEEF || bus.err !== 1'b0) begin
      $display("FAIL rd_data: rvalid=%b rdata=%h err=%b want 01 deadbeef 0",
               bus.rvalid, bus.rdata, bus.err); n_fail++; end
    @(negedge clk);
    idle();
  endtask

  task automatic test_range();
    bus.req = 2'b01; bus.we = 2'b01;
    bus.addr[0] = 32'h2000; bus.wdata[0] = 32'h12345678;
    #1;
    n_checks++; if (ram_we !== 1'b0) begin
      $display("FAIL range_wr_we: got %b want 0", ram_we); n_fail++; end
    @(posedge clk); #1;
    n_checks++; if (bus.rvalid !== 2'b01 || bus.err !== 1'b1) begin
      $display("FAIL range_wr_err: rvalid=%b err=%b want 01 1", bus.rvalid, bus.err);
      n_fail++; end
    @(negedge clk);
    bus.we = 2'b00; bus.addr[0] = 32'h0FFC;
    @(posedge clk); #1;
    n_checks++; if (bus.rvalid !== 2'b01 || bus.rdata !== 32'h0 || bus.err !== 1'b1) begin
      $display("FAIL range_rd: rvalid=%b rdata=%h err=%b want 01 0 1",
               bus.rvalid, bus.rdata, bus.err); n_fail++; end
    @(negedge clk);
    bus.we = 2'b01; bus.addr[0] = 32'h1FFF; bus.wdata[0] = 32'hA5A5A5A5;
    #1;
    n_checks++; if (ram_we !== 1'b1 || ram_a !== 10'd1023) begin
      $display("FAIL range_top: we=%b a=%0d want 1 1023", ram_we, ram_a); n_fail++; end
    @(posedge clk); #1;
    n_checks++; if (bus.rvalid !== 2'b00 || mem[1023] !== 32'hA5A5A5A5) begin
      $display("FAIL range_top_wr: rvalid=%b mem=%h want 00 a5a5a5a5", bus.rvalid, mem[1023]);
      n_fail++; end
    @(negedge clk);
    idle();
  endtask

  task automatic test_burst();
    int m1_cnt;
    m1_cnt = 0;
    bus.req = 2'b11; bus.lock = 2'b10; bus.we = 2'b00;
    bus.addr[0] = 32'h1000; bus.addr[1] = 32'h1004;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (bus.gnt == 2'b10) m1_cnt++;
      @(negedge clk);
    end
    n_checks++; if (m1_cnt !== 8) begin
      $display("FAIL burst_len: got %0d grants want 8", m1_cnt); n_fail++; end
    n_checks++; if (bus.rvalid !== 2'b10 || bus.rdata !== 32'hDEADBEEF) begin
      $display("FAIL burst_rdata: rvalid=%b rdata=%h want 10 deadbeef", bus.rvalid, bus.rdata);
      n_fail++; end
    #1;
    n_checks++; if (bus.gnt !== 2'b00) begin
      $display("FAIL burst_exit: got %b want 00", bus.gnt); n_fail++; end
    @(negedge clk); #1;
    n_checks++; if (bus.gnt !== 2'b01) begin
      $display("FAIL burst_next: got %b want 01", bus.gnt); n_fail++; end
    @(negedge clk);
    idle();
  endtask

  task automatic test_reset_mid_burst();
    bus.req = 2'b11; bus.lock = 2'b10; bus.we = 2'b00;
    bus.addr[1] = 32'h1004;
    #1;
    n_checks++; if (bus.gnt !== 2'b10) begin
      $display("FAIL mid_first: got %b want 10", bus.gnt); n_fail++; end
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (bus.rvalid !== 2'b10) begin
      $display("FAIL mid_rvalid: got %b want 10", bus.rvalid); n_fail++; end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus.gnt !== 2'b00 || bus.rvalid !== 2'b00 || bus.rdata !== 32'h0
                    || bus.err !== 1'b0 || ram_we !== 1'b0) begin
      $display("FAIL mid_reset: gnt=%b rvalid=%b rdata=%h err=%b we=%b want all 0",
               bus.gnt, bus.rvalid, bus.rdata, bus.err, ram_we); n_fail++; end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++; if (bus.gnt !== 2'b01) begin
      $display("FAIL mid_restart: got %b want 01", bus.gnt); n_fail++; end
    @(negedge clk);
    idle();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    bus.addr  = '0;
    bus.wdata = '0;
    test_reset();
    test_contention();
    test_write_read();
    test_range();
    test_burst();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
